// File: rtl/dec_pkg.sv
// Shared mode encodings and the active-low one-hot helper for the dec_scan_n decoder.
package dec_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Returns ~(1<<idx) at width n; an index outside 0..n-1 selects nothing.
  function automatic logic [31:0] onehot_low(input int unsigned idx, input int unsigned n);
    logic [31:0] v;
    v = '1;
    if (idx < n && idx < 32) v[idx[4:0]] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/dec_tick_gen.sv
// Scan prescaler: counts while run is high and pulses step once cnt reaches presc.
module dec_tick_gen #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               step
);

  logic [PRESC_W-1:0] cnt;

  // >= rather than == so a mid-slot reduction of presc steps on the next cycle.
  assign step = run && (cnt >= presc);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run) begin
      if (step) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dec_scan_n.sv
// Registered N-to-2^N decoder with DIRECT and SCAN modes, active-low one-hot outputs.
// Optional anti-ghosting blanking of the first slot cycle: define DEC_SCAN_DEADTIME_EN.
module dec_scan_n
  import dec_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int PRESC_W = 16,
  localparam int N_OUT  = 2**SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   a,
  input  logic [PRESC_W-1:0] presc,
  output logic [N_OUT-1:0]   y,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  logic             step;
  logic             run;
  logic             clr;
  logic [SEL_W-1:0] idx_inc;
  logic [N_OUT-1:0] y_cur;
  logic [N_OUT-1:0] y_inc;
  logic [N_OUT-1:0] y_a;
  logic             blank_step;

  assign run     = en && (mode == MODE_SCAN);
  assign clr     = (mode == MODE_DIRECT);
  assign idx_inc = idx + 1'b1;

  always_comb begin
    y_cur = N_OUT'(onehot_low(32'(idx), N_OUT));
    y_inc = N_OUT'(onehot_low(32'(idx_inc), N_OUT));
    y_a   = N_OUT'(onehot_low(32'(a), N_OUT));
  end

`ifdef DEC_SCAN_DEADTIME_EN
  // With presc = 0 every cycle is a new slot, so blanking would hide y entirely.
  assign blank_step = (presc != '0);
`else
  assign blank_step = 1'b0;
`endif

  dec_tick_gen #(.PRESC_W(PRESC_W)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clr   (clr),
    .presc (presc),
    .step  (step)
  );

`ifdef DEC_SCAN_DEADTIME_EN
  logic blank;

  always_ff @(posedge clk) begin
    if (rst || !run) blank <= 1'b0;
    else             blank <= step && blank_step;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      y    <= '1;
      idx  <= '0;
      wrap <= 1'b0;
    end else if (mode == MODE_DIRECT) begin
      wrap <= 1'b0;
      if (en) begin
        y   <= y_a;
        idx <= a;
      end else begin
        y   <= '1;
      end
    end else if (!en) begin
      y    <= '1;
      wrap <= 1'b0;
    end else if (step) begin
      idx  <= idx_inc;
      wrap <= (idx == SEL_W'(N_OUT-1));
      y    <= blank_step ? '1 : y_inc;
    end else begin
      y    <= y_cur;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dec_scan_n.sv
// Self-checking bench for dec_scan_n (SEL_W=2): directed literal checks plus randomized traffic.
module tb_dec_scan_n;

  localparam int SEL_W   = 2;
  localparam int PRESC_W = 16;
  localparam int N_OUT   = 4;
`ifdef DEC_SCAN_DEADTIME_EN
  localparam bit DEAD = 1'b1;
`else
  localparam bit DEAD = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   a;
  logic [PRESC_W-1:0] presc;
  logic [N_OUT-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  int vectors;
  int miscompares;

  dec_scan_n #(.SEL_W(SEL_W), .PRESC_W(PRESC_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .a     (a),
    .presc (presc),
    .y     (y),
    .idx   (idx),
    .wrap  (wrap)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: slot position and current index, outputs from the stated rules.
  int m_idx;
  int m_pos;
  logic [N_OUT-1:0] m_y;
  logic             m_wrap;
  logic [N_OUT+SEL_W:0] exp_q[$];

  function automatic logic [N_OUT-1:0] sel_low(input int i);
    logic [N_OUT-1:0] ones;
    logic [N_OUT-1:0] bitv;
    ones = '1;
    bitv = '0;
    bitv[i] = 1'b1;
    return ones ^ bitv;
  endfunction

  initial begin
    m_idx = 0; m_pos = 0; m_y = '1; m_wrap = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_idx = 0; m_pos = 0; m_y = '1; m_wrap = 1'b0;
    end else if (mode == 1'b0) begin
      m_pos = 0; m_wrap = 1'b0;
      if (en) begin m_idx = int'(a); m_y = sel_low(m_idx); end
      else    m_y = '1;
    end else if (!en) begin
      m_y = '1; m_wrap = 1'b0;
    end else if (m_pos >= int'(presc)) begin
      m_wrap = (m_idx == N_OUT-1);
      m_idx  = (m_idx + 1) % N_OUT;
      m_pos  = 0;
      m_y    = (DEAD && presc != 0) ? '1 : sel_low(m_idx);
    end else begin
      m_pos  = m_pos + 1;
      m_wrap = 1'b0;
      m_y    = sel_low(m_idx);
    end
    exp_q.push_back({m_wrap, SEL_W'(m_idx), m_y});
  end

  // Scoreboard: compares every cycle, #1 after the edge.
  always @(posedge clk) begin
    logic [N_OUT+SEL_W:0] e;
    #1;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL sb_empty: no expected entry at time %0t", $time);
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if ({wrap, idx, y} !== e) begin
        miscompares++;
        $display("FAIL sb_cycle t=%0t: got wrap=%b idx=%0d y=%b, need wrap=%b idx=%0d y=%b",
                 $time, wrap, idx, y, e[N_OUT+SEL_W], e[N_OUT+SEL_W-1:N_OUT], e[N_OUT-1:0]);
      end
      vectors++;
      if ($countones(~y) > 1 || $isunknown(y)) begin
        miscompares++;
        $display("FAIL onehot_low t=%0t: y=%b has more than one low bit", $time, y);
      end
    end
  end

  // Driver: inputs change on the falling edge, checks run 2 time units after the rising edge.
  task automatic cyc(input logic r, input logic e, input logic m,
                     input logic [SEL_W-1:0] aa, input logic [PRESC_W-1:0] p);
    @(negedge clk);
    rst = r; en = e; mode = m; a = aa; presc = p;
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int got, input int need);
    vectors++;
    if (got != need) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), need %0d (0x%0h)", name, got, got, need, need);
    end
  endtask

  logic [3:0] seq_y[12];
  int wraps;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; en = 1'b1; mode = 1'b1; a = '0; presc = 16'd2;

    // 1: reset wins over an enabled scan
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 1, 0, 2);
      check("rst_y", int'(y), 4'b1111);
      check("rst_idx", int'(idx), 0);
      check("rst_wrap", int'(wrap), 0);
    end

    // 2: direct decode and disable
    cyc(0, 1, 0, 2'b10, 2);
    check("direct_y", int'(y), 4'b1011);
    check("direct_idx", int'(idx), 2);
    cyc(0, 0, 0, 2'b10, 2);
    check("direct_off_y", int'(y), 4'b1111);
    check("direct_off_idx", int'(idx), 2);

    // 3 / 6: scan presc=2 from reset, full lap
    cyc(1, 1, 1, 0, 2);
    if (DEAD) seq_y = '{4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1111,
                       4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b1111};
    else      seq_y = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1101, 4'b1011,
                       4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b0111, 4'b1110};
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 1, 0, 2);
      check($sformatf("scan_y[%0d]", i), int'(y), int'(seq_y[i]));
      check($sformatf("scan_wrap[%0d]", i), int'(wrap), (i == 11) ? 1 : 0);
    end
    check("scan_lap_idx", int'(idx), 0);

    // 4: enable dropped mid-slot resumes with the remaining count
    cyc(1, 1, 1, 0, 4);
    cyc(0, 1, 1, 0, 4);
    cyc(0, 1, 1, 0, 4);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 4);
      check("freeze_y", int'(y), 4'b1111);
      check("freeze_idx", int'(idx), 0);
    end
    cyc(0, 1, 1, 0, 4);
    check("resume1_y", int'(y), 4'b1110);
    cyc(0, 1, 1, 0, 4);
    check("resume2_y", int'(y), 4'b1110);
    cyc(0, 1, 1, 0, 4);
    check("resume_step_idx", int'(idx), 1);
    check("resume_step_y", int'(y), DEAD ? 4'b1111 : 4'b1101);

    // 5: presc shrunk mid-slot, then presc=0
    cyc(1, 1, 1, 0, 10);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 10);
    check("long_slot_idx", int'(idx), 0);
    cyc(0, 1, 1, 0, 1);
    check("shrink_step_idx", int'(idx), 1);
    wraps = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 0, 0);
      check("presc0_idx", int'(idx), (2 + i) % 4);
      check("presc0_y", int'(y), int'(sel_low((2 + i) % 4)));
      wraps += int'(wrap);
    end
    check("presc0_wraps", wraps, 2);

    // Randomized traffic against the model
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic r, e, m;
      logic [PRESC_W-1:0] p;
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 99) < 85);
      m = ($urandom_range(0, 29) == 0) ? ~mode : mode;
      p = ($urandom_range(0, 9) == 0) ? PRESC_W'($urandom_range(0, 5)) : presc;
      cyc(r, e, m, SEL_W'($urandom_range(0, N_OUT-1)), p);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
